// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment frame sequencer.
// A frame is four active-low digit patterns plus a dwell time in clock cycles.
package sseg_pkg;

    localparam int SSEG_DEPTH = 8;
    localparam int DWELL_W    = 27;

    localparam logic [6:0] BLANK = 7'b1111111;

    typedef struct packed {
        logic [3:0][6:0]      dig;
        logic [DWELL_W-1:0]   dwell;
    } frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam frame_t BLANK_FRAME = '{dig: {4{BLANK}}, dwell: DWELL_W'(1)};

    // Terminal counter value for a dwell; a zero dwell behaves as a one-cycle dwell.
    function automatic logic [DWELL_W-1:0] last_tick(input logic [DWELL_W-1:0] dwell);
        return (dwell == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}} : dwell - DWELL_W'(1);
    endfunction

endpackage

// File: rtl/sseg_frame_store.sv
// Frame table: DEPTH entries, one synchronous write port and one combinational read port.
// Reads return the pre-write contents during a same-cycle write to the same entry.
module sseg_frame_store
    import sseg_pkg::*;
#(
    parameter  int DEPTH = SSEG_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  frame_t        wr_frame_i,
    input  logic [AW-1:0] rd_addr_i,
    output frame_t        rd_frame_o
);

    frame_t r_mem [DEPTH];

    // Table storage: cleared to blank one-cycle frames on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= BLANK_FRAME;
            end
        end else if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_frame_i;
        end
    end

    assign rd_frame_o = r_mem[rd_addr_i];

endmodule

// File: rtl/sseg_frame_sequencer.sv
// Plays frames 0..len-1 from the frame table onto the four digit outputs,
// holding each frame for its dwell time, once or looping.
module sseg_frame_sequencer
    import sseg_pkg::*;
#(
    parameter  int DEPTH = SSEG_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [27:0]        wr_seg_i,
    input  logic [DWELL_W-1:0] wr_dwell_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [LW-1:0]      len_i,
    input  logic               loop_i,
    output logic [6:0]         in0_o,
    output logic [6:0]         in1_o,
    output logic [6:0]         in2_o,
    output logic [6:0]         in3_o,
    output logic               busy_o,
    output logic [AW-1:0]      frame_idx_o,
    output logic               done_o
);

    state_t             r_state, w_state_nxt;
    logic [AW-1:0]      r_idx, w_idx_nxt;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
    logic [DWELL_W-1:0] r_last, w_last_nxt;
    logic [LW-1:0]      r_len, w_len_nxt;
    logic               r_loop, w_loop_nxt;
    logic [3:0][6:0]    r_dig, w_dig_nxt;
    logic               r_done, w_done_nxt;

    frame_t             w_wr_frame;
    frame_t             w_rd_frame;
    logic [AW-1:0]      w_rd_addr;
    logic [LW-1:0]      w_len_eff;
    logic               w_final_frame;
    logic [AW-1:0]      w_idx_inc;

    assign w_wr_frame    = '{dig: wr_seg_i, dwell: wr_dwell_i};
    assign w_len_eff     = (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
    assign w_final_frame = (LW'(r_idx) == (r_len - LW'(1)));
    assign w_idx_inc     = r_idx + AW'(1);
    // The read port always points at whichever entry would be loaded at the next frame boundary.
    assign w_rd_addr     = ((r_state == SHOW) && !w_final_frame) ? w_idx_inc : {AW{1'b0}};

    sseg_frame_store #(.DEPTH(DEPTH)) u_store (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_frame_i (w_wr_frame),
        .rd_addr_i  (w_rd_addr),
        .rd_frame_o (w_rd_frame)
    );

    // Next-state and next-output logic for the playback FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_len_nxt   = r_len;
        w_loop_nxt  = r_loop;
        w_dig_nxt   = r_dig;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_dig_nxt = {4{BLANK}};
                if (start_i && (len_i != LW'(0)) && !stop_i) begin
                    w_state_nxt = SHOW;
                    w_len_nxt   = w_len_eff;
                    w_loop_nxt  = loop_i;
                    w_idx_nxt   = {AW{1'b0}};
                    w_cnt_nxt   = {DWELL_W{1'b0}};
                    w_dig_nxt   = w_rd_frame.dig;
                    w_last_nxt  = last_tick(w_rd_frame.dwell);
                end else begin
                    w_idx_nxt   = {AW{1'b0}};
                end
            end
            SHOW: begin
                if (stop_i) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = {AW{1'b0}};
                    w_cnt_nxt   = {DWELL_W{1'b0}};
                    w_dig_nxt   = {4{BLANK}};
                end else if (r_cnt == r_last) begin
                    w_cnt_nxt = {DWELL_W{1'b0}};
                    if (!w_final_frame || r_loop) begin
                        // w_rd_addr already selects idx+1, or 0 on wrap.
                        w_idx_nxt  = w_rd_addr;
                        w_dig_nxt  = w_rd_frame.dig;
                        w_last_nxt = last_tick(w_rd_frame.dwell);
                    end else begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = {AW{1'b0}};
                        w_dig_nxt   = {4{BLANK}};
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DWELL_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = {AW{1'b0}};
                w_cnt_nxt   = {DWELL_W{1'b0}};
                w_dig_nxt   = {4{BLANK}};
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_idx   <= {AW{1'b0}};
            r_cnt   <= {DWELL_W{1'b0}};
            r_last  <= {DWELL_W{1'b0}};
            r_len   <= {LW{1'b0}};
            r_loop  <= 1'b0;
            r_dig   <= {4{BLANK}};
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_len   <= w_len_nxt;
            r_loop  <= w_loop_nxt;
            r_dig   <= w_dig_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign in0_o       = r_dig[0];
    assign in1_o       = r_dig[1];
    assign in2_o       = r_dig[2];
    assign in3_o       = r_dig[3];
    assign busy_o      = (r_state == SHOW);
    assign frame_idx_o = r_idx;
    assign done_o      = r_done;

endmodule

// File: tb/tb_sseg_frame_sequencer.sv
// Directed bench for sseg_frame_sequencer: a cycle-level playback model is compared
// on every falling edge, plus hand-computed checks at key cycles of each scenario.
module tb_sseg_frame_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int LW    = 4;
    localparam int DW    = 27;
    localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [27:0]   wr_seg = '0;
    logic [DW-1:0] wr_dwell = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [LW-1:0] len = '0;
    logic          loop = 1'b0;
    logic [6:0]    in0, in1, in2, in3;
    logic          busy, done;
    logic [AW-1:0] fidx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sseg_frame_sequencer dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_seg_i(wr_seg), .wr_dwell_i(wr_dwell), .start_i(start), .stop_i(stop),
        .len_i(len), .loop_i(loop), .in0_o(in0), .in1_o(in1), .in2_o(in2), .in3_o(in3),
        .busy_o(busy), .frame_idx_o(fidx), .done_o(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [27:0] mt_seg [DEPTH];
    int          mt_dw  [DEPTH];
    logic [27:0] m_out = ALL_OFF;
    bit          m_valid = 0, m_busy = 0, m_loop = 0, m_done = 0;
    int          m_idx = 0, m_left = 0, m_len = 0;

    task automatic mload(input int i);
        m_out  = mt_seg[i];
        m_left = (mt_dw[i] == 0) ? 1 : mt_dw[i];
    endtask

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mt_seg[i] = ALL_OFF;
                mt_dw[i]  = 1;
            end
            m_busy = 0; m_done = 0; m_idx = 0; m_left = 0; m_out = ALL_OFF; m_valid = 1;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start && len != 0 && !stop) begin
                    m_busy = 1;
                    m_len  = (int'(len) > DEPTH) ? DEPTH : int'(len);
                    m_loop = loop;
                    m_idx  = 0;
                    mload(0);
                end
            end else if (stop) begin
                m_busy = 0; m_idx = 0; m_out = ALL_OFF;
            end else if (m_left > 1) begin
                m_left--;
            end else if (m_idx < m_len - 1) begin
                m_idx++;
                mload(m_idx);
            end else if (m_loop) begin
                m_idx = 0;
                mload(0);
            end else begin
                m_busy = 0; m_done = 1; m_idx = 0; m_out = ALL_OFF;
            end
            // table update after any load this edge: loads see the old contents
            if (wr_en) begin
                mt_seg[wr_addr] = wr_seg;
                mt_dw[wr_addr]  = int'(wr_dwell);
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_valid) begin
            check("in0", in0, m_out[6:0]);
            check("in1", in1, m_out[13:7]);
            check("in2", in2, m_out[20:14]);
            check("in3", in3, m_out[27:21]);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            if (m_busy) check("frame_idx", fidx, m_idx);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [27:0] s, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_seg = s; wr_dwell = DW'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go(input int l, input bit lp);
        start = 1'b1; len = LW'(l); loop = lp;
        tick();
        start = 1'b0;
    endtask

    logic [27:0] s0 = 28'h1234567, s1 = 28'h89ABCDE, s2 = 28'h5A5A5A5;
    logic [27:0] s3 = 28'h0F0F0F0, s4 = 28'h3C3C3C3, s5 = 28'h7654321;
    logic [27:0] s6 = 28'h0123456, s7 = 28'h6DB6DB6;

    initial begin
        int nb;
        bit seen;
        // 1. reset and blank replay
        tick(2);
        check("rst_in0", in0, 7'h7F);
        check("rst_in3", in3, 7'h7F);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();
        go(3, 0);                       // cycle 1
        check("blank_busy_c1", busy, 1'b1);
        check("blank_in0_c1", in0, 7'h7F);
        tick(3);                        // cycle 4
        check("blank_done_c4", done, 1'b1);
        tick(2);

        // 2. three frames, dwell 4, one-shot
        wr(0, s0, 4); wr(1, s1, 4); wr(2, s2, 4);
        go(3, 0);                       // cycle 1
        check("t2_in0_c1", in0, s0[6:0]);
        check("t2_idx_c1", fidx, 3'd0);
        tick(4);                        // cycle 5
        check("t2_idx_c5", fidx, 3'd1);
        check("t2_in3_c5", in3, s1[27:21]);
        tick(4);                        // cycle 9
        check("t2_idx_c9", fidx, 3'd2);
        tick(3);                        // cycle 12
        check("t2_done_c12", done, 1'b0);
        tick();                         // cycle 13
        check("t2_done_c13", done, 1'b1);
        check("t2_busy_c13", busy, 1'b0);
        check("t2_in2_c13", in2, 7'h7F);
        tick(2);

        // 3. same table, looping, stop in cycle 18
        go(3, 1);                       // cycle 1
        tick(12);                       // cycle 13
        check("t3_idx_c13", fidx, 3'd0);
        check("t3_in0_c13", in0, s0[6:0]);
        tick(4);                        // cycle 17
        check("t3_idx_c17", fidx, 3'd1);
        tick();                         // cycle 18
        stop = 1'b1;
        tick();                         // cycle 19
        stop = 1'b0;
        check("t3_stop_in0", in0, 7'h7F);
        check("t3_stop_busy", busy, 1'b0);
        check("t3_stop_done", done, 1'b0);
        tick(2);

        // 4. zero dwell single looping frame, len 0, len 15
        wr(0, s3, 0);
        go(1, 1);                       // cycle 1
        tick(3);                        // cycle 4
        check("t4_idx", fidx, 3'd0);
        check("t4_busy", busy, 1'b1);
        wr(0, s4, 0);                   // cycle 5: load coincided with write
        check("t4_old", in0, s3[6:0]);
        tick();                         // cycle 6
        check("t4_new", in0, s4[6:0]);
        stop = 1'b1; tick(); stop = 1'b0;
        go(0, 0);
        check("t4_len0_busy", busy, 1'b0);
        tick();
        check("t4_len0_busy2", busy, 1'b0);
        for (int i = 0; i < DEPTH; i++) wr(i, 28'h0204081 * 28'(i + 1), 1);
        go(15, 0);                      // cycle 1
        nb = 0;
        seen = 0;
        for (int c = 1; c <= 12; c++) begin
            if (busy) nb++;
            if (done) begin
                check("t4_done_cycle", c, 9);
                seen = 1;
            end
            tick();
        end
        check("t4_busy_cycles", nb, 8);
        check("t4_done_seen", seen, 1'b1);

        // 5. rewrites during playback
        wr(0, s0, 4); wr(1, s1, 4); wr(2, s2, 4);
        go(3, 0);                       // cycle 1
        tick();                         // cycle 2
        wr(0, s5, 4);                   // cycle 3
        wr(1, s6, 2);                   // cycle 4
        check("t5_cur_keep", in0, s0[6:0]);
        tick();                         // cycle 5
        check("t5_next_new", in0, s6[6:0]);
        tick();                         // cycle 6
        wr(2, s7, 4);                   // cycle 7
        check("t5_rbw_old", in0, s2[6:0]);
        check("t5_rbw_idx", fidx, 3'd2);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (!busy) seen = 1;
            else tick();
        end
        check("t5_finished", seen, 1'b1);
        tick();

        // 6. start+stop in idle, start while busy, reset mid-frame
        start = 1'b1; stop = 1'b1; len = 4'd3;
        tick();
        start = 1'b0; stop = 1'b0;
        check("t6_startstop", busy, 1'b0);
        go(3, 0);                       // cycle 1
        tick();                         // cycle 2
        go(3, 1);                       // cycle 3, ignored
        check("t6_ign_idx", fidx, 3'd0);
        tick(3);                        // cycle 6
        check("t6_ign_idx6", fidx, 3'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_in1", in1, 7'h7F);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_idx", fidx, 3'd0);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
